// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: default operand/accumulator/address
// widths and the sequencer state encoding.
package mac_pkg;
   localparam int DEF_DATA_WIDTH   = 16;  // S5.10 data operand
   localparam int DEF_WEIGHT_WIDTH = 8;   // S1.6 weight operand
   localparam int DEF_ACCUM_WIDTH  = 24;  // S7.16 accumulator
   localparam int DEF_ADDR_WIDTH   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;
endpackage

// File: rtl/mac_addr_gen.sv
// Loadable base+index address generator shared by the data and weight memories.
// Ports:
//   clk, rst_n                clock, async active-low reset
//   load                      capture len and both bases, clear idx
//   step                      advance idx and both addresses by one
//   len, data_base, weight_base  command fields captured on load
//   idx                       element index of the current read
//   data_addr, weight_addr    registered memory addresses (wrap modulo 2^AW)
//   last                      idx is the final element of the command
module mac_addr_gen
   import mac_pkg::*;
#(
   parameter int AW = DEF_ADDR_WIDTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          step,
   input  logic [AW-1:0] len,
   input  logic [AW-1:0] data_base,
   input  logic [AW-1:0] weight_base,
   output logic [AW-1:0] idx,
   output logic [AW-1:0] data_addr,
   output logic [AW-1:0] weight_addr,
   output logic          last
);
   logic [AW-1:0] len_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q       <= '0;
         idx         <= '0;
         data_addr   <= '0;
         weight_addr <= '0;
      end else if (load) begin
         len_q       <= len;
         idx         <= '0;
         data_addr   <= data_base;
         weight_addr <= weight_base;
      end else if (step) begin
         idx         <= idx + AW'(1);
         data_addr   <= data_addr + AW'(1);
         weight_addr <= weight_addr + AW'(1);
      end
   end

   // Only meaningful while reading, where len_q is known to be non-zero.
   assign last = (idx == len_q - AW'(1));
endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for the shared MAC unit. A command streams vec_len
// data/weight pairs from two 1-cycle-latency memories into the MAC, then holds
// the accumulator on a valid/ready result port until it is taken.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   start, vec_len, data_base, weight_base   command (accepted in IDLE only)
//   busy, done                       not-idle flag, one-cycle result-taken pulse
//   mem_rd_en, data_addr, weight_addr, data_rdata, weight_rdata   memory reads
//   mac_enable, mac_clear, mac_data, mac_weight, mac_accum        MAC interface
//   result_valid, result_ready, result_data                      result port
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
   parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   vec_len,
   input  logic [ADDR_WIDTH-1:0]   data_base,
   input  logic [ADDR_WIDTH-1:0]   weight_base,
   output logic                    busy,
   output logic                    done,
   output logic                    mem_rd_en,
   output logic [ADDR_WIDTH-1:0]   data_addr,
   output logic [ADDR_WIDTH-1:0]   weight_addr,
   input  logic [DATA_WIDTH-1:0]   data_rdata,
   input  logic [WEIGHT_WIDTH-1:0] weight_rdata,
   output logic                    mac_enable,
   output logic                    mac_clear,
   output logic [DATA_WIDTH-1:0]   mac_data,
   output logic [WEIGHT_WIDTH-1:0] mac_weight,
   input  logic [ACCUM_WIDTH-1:0]  mac_accum,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic [ACCUM_WIDTH-1:0]  result_data
);
   state_t                state, state_nxt;
   logic                  load, step, last;
   logic                  zero_q;
   logic                  handshake;
   logic [ADDR_WIDTH-1:0] idx;

   mac_addr_gen #(.AW(ADDR_WIDTH)) u_addr_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .step        (step),
      .len         (vec_len),
      .data_base   (data_base),
      .weight_base (weight_base),
      .idx         (idx),
      .data_addr   (data_addr),
      .weight_addr (weight_addr),
      .last        (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: if (start) begin
            load      = 1'b1;
            state_nxt = (vec_len == '0) ? HOLD : READ;
         end
         READ: begin
            step = 1'b1;
            if (last) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = HOLD;
         HOLD:  if (result_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign handshake    = (state == HOLD) && result_ready;
   assign busy         = (state != IDLE);
   assign mem_rd_en    = (state == READ);
   assign result_valid = (state == HOLD);

   // MAC controls trail the read strobe by the memory latency; the first
   // element of a command loads the product instead of accumulating onto
   // whatever the previous command left behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mac_enable <= 1'b0;
         mac_clear  <= 1'b0;
         done       <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         mac_enable <= mem_rd_en;
         mac_clear  <= mem_rd_en && (idx == '0);
         done       <= handshake;
         if (load)           zero_q <= (vec_len == '0);
         else if (handshake) zero_q <= 1'b0;
      end
   end

   assign mac_data   = mac_enable ? data_rdata   : '0;
   assign mac_weight = mac_enable ? weight_rdata : '0;

   // An empty command never touches the MAC, so its stale accumulator is masked.
   assign result_data = (result_valid && !zero_q) ? mac_accum : '0;
endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer that computes one dot product per command on the shared multiply-accumulate unit. On start it streams N data/weight operand pairs from two single-port read memories (1-cycle read latency) into the MAC, drives its enable/clear controls, and presents the final accumulator value on a valid/ready result port. It sits between the layer-level scheduler, which issues commands, and the MAC datapath.

Parameters:
DATA_WIDTH, 16, data operand width (S5.10)
WEIGHT_WIDTH, 8, weight operand width (S1.6)
ACCUM_WIDTH, 24, accumulator/result width (S7.16)
ADDR_WIDTH, 8, memory address width; vec_len range 0..2^ADDR_WIDTH-1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  command strobe; accepted only in IDLE
vec_len  in  ADDR_WIDTH  element count N, sampled with start
data_base  in  ADDR_WIDTH  data memory start address, sampled with start
weight_base  in  ADDR_WIDTH  weight memory start address, sampled with start
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on result handshake
mem_rd_en  out  1  read strobe to both memories
data_addr  out  ADDR_WIDTH  data memory address
weight_addr  out  ADDR_WIDTH  weight memory address
data_rdata  in  DATA_WIDTH  data read, valid the cycle after mem_rd_en
weight_rdata  in  WEIGHT_WIDTH  weight read, valid the cycle after mem_rd_en
mac_enable  out  1  MAC enable
mac_clear  out  1  MAC clear_accum (load the product instead of accumulating)
mac_data  out  DATA_WIDTH  MAC data operand
mac_weight  out  WEIGHT_WIDTH  MAC weight operand
mac_accum  in  ACCUM_WIDTH  MAC accumulator output
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_data  out  ACCUM_WIDTH  dot-product result

Behaviour:
- Reset values (async): state=IDLE, busy=0, done=0, mem_rd_en=0, mac_enable=0, mac_clear=0, result_valid=0, addresses=0, counters=0.
- States: IDLE, READ, DRAIN, HOLD.
- IDLE: on an edge where start=1, latch vec_len and both bases.
  - N>0: go to READ, idx=0.
  - N=0: go to HOLD with the zero flag set.
- READ:
  - mem_rd_en=1; data_addr=data_base+idx; weight_addr=weight_base+idx. Addresses are registered and wrap modulo 2^ADDR_WIDTH.
  - idx increments each cycle. After N read cycles, go to DRAIN.
- MAC drive:
  - mac_enable and mac_clear are registered copies of mem_rd_en and (mem_rd_en && idx==0), delayed one cycle.
  - mac_data/mac_weight pass data_rdata/weight_rdata through combinationally. They are forced to 0 when mac_enable=0.
- DRAIN: one cycle; the last element's mac_enable is high here. Next edge: go to HOLD.
- HOLD:
  - result_valid=1; result_data=mac_accum, or 0 if the zero flag is set. mac_enable stays 0, so the value is stable.
  - On an edge with result_ready=1: go to IDLE, pulse done for the following cycle, clear the zero flag.
  - result_data must not change while result_valid=1 and result_ready=0.
- Latency: start edge to first cycle with result_valid=1 is N+1 cycles for N>0, and 1 cycle for N=0.
- Arithmetic: no saturation in this block. The MAC's wrap-around accumulate is passed through unchanged.
- start while busy is ignored. This includes start in the same cycle as the HOLD handshake; a new command needs start in IDLE.
- vec_len/base changes while busy have no effect.
- Reset mid-operation: immediate return to IDLE. No result is produced and done is not pulsed. mac_enable drops asynchronously, so the MAC accumulator is left stale (cleared by the next command's mac_clear).
- result_ready while not in HOLD is ignored.

Decomposition:
- Package mac_pkg: width constants (DATA_WIDTH, WEIGHT_WIDTH, ACCUM_WIDTH, ADDR_WIDTH defaults) and the state enum (IDLE, READ, DRAIN, HOLD).
- One sub-module, mac_addr_gen: loadable base+index counter with terminal-count flag, instantiated once and driving both addresses from the shared idx.
- Bench instantiates mac_seq_ctrl plus the real MAC and two behavioural 1-cycle-latency memories.

Test Plan:
- N=3, data=[2,3,-1] (S5.10 raw 0x0800,0x0C00,0xFC00), weights=[4,-2,5] raw, ready=1 -> result_valid 4 cycles after the start edge; result=(8-6-5)·2^10 raw, sign-extended; done pulses once; mac_clear high only on the first mac_enable cycle.
- Back-to-back commands, second N=2 with different data -> second result excludes the first accumulation (mac_clear applied); first-command start during busy ignored.
- N=0 -> result_valid 1 cycle after start, result_data=0, mem_rd_en and mac_enable never asserted.
- Backpressure: result_ready low 5 cycles in HOLD -> result_valid and result_data stable; done only after the ready edge.
- Address wrap: data_base=0xFE, N=4 -> data_addr sequence 0xFE,0xFF,0x00,0x01; results match the golden model.
- rst_n asserted mid-READ (N=8, after 3 reads) -> all outputs at reset values immediately; after release, a fresh N=2 command produces the correct result.
